// File: rtl/color_pkg.sv
// Shared definitions for the color FSM and its command transmitter:
// state encoding, command codes, output codes and small helper functions.
package color_pkg;

  typedef enum logic [1:0] {
    COLOR_BLUE     = 2'd0,
    COLOR_RED      = 2'd1,
    COLOR_HSV_IDLE = 2'd2
  } color_e;

  localparam logic [1:0] CMD_TO_RED = 2'd0;
  localparam logic [1:0] CMD_TOGGLE = 2'd1;
  localparam logic [1:0] CMD_TO_HSV = 2'd2;
  localparam logic [1:0] CMD_NOP    = 2'd3;

  localparam logic [1:0] OUT_BLUE = 2'd1;
  localparam logic [1:0] OUT_RED  = 2'd2;

  // State reached by the downstream FSM after it consumes one command.
  function automatic logic [1:0] color_next(input logic [1:0] st, input logic [1:0] c);
    logic [1:0] nxt;
    nxt = st;
    case (c)
      CMD_TOGGLE: begin
        if (st == COLOR_BLUE)     nxt = COLOR_RED;
        else if (st == COLOR_RED) nxt = COLOR_BLUE;
        else                      nxt = st;
      end
      CMD_TO_HSV: begin
        if (st == COLOR_RED) nxt = COLOR_HSV_IDLE;
        else                 nxt = st;
      end
      CMD_TO_RED: begin
        if (st == COLOR_HSV_IDLE) nxt = COLOR_RED;
        else                      nxt = st;
      end
      default: nxt = st;
    endcase
    return nxt;
  endfunction

  // Value the downstream FSM shows on its out port in a given state.
  function automatic logic [1:0] color_out(input logic [1:0] st);
    return (st == COLOR_BLUE) ? OUT_BLUE : OUT_RED;
  endfunction

endpackage

// File: rtl/color_tx_path.sv
// Combinational path planner: command steps from the shadow state to the
// requested target. Illegal targets or shadows yield a zero-step path.
module color_tx_path
  import color_pkg::*;
(
  input  logic [1:0] shadow,
  input  logic [1:0] target,
  output logic [1:0] nsteps,
  output logic [1:0] step0,
  output logic [1:0] step1
);

  // Lookup of the at-most-two-step command path for each (shadow, target) pair.
  always_comb begin
    nsteps = 2'd0;
    step0  = CMD_NOP;
    step1  = CMD_NOP;
    case ({shadow, target})
      {COLOR_BLUE, COLOR_RED}: begin
        nsteps = 2'd1; step0 = CMD_TOGGLE;
      end
      {COLOR_BLUE, COLOR_HSV_IDLE}: begin
        nsteps = 2'd2; step0 = CMD_TOGGLE; step1 = CMD_TO_HSV;
      end
      {COLOR_RED, COLOR_BLUE}: begin
        nsteps = 2'd1; step0 = CMD_TOGGLE;
      end
      {COLOR_RED, COLOR_HSV_IDLE}: begin
        nsteps = 2'd1; step0 = CMD_TO_HSV;
      end
      {COLOR_HSV_IDLE, COLOR_RED}: begin
        nsteps = 2'd1; step0 = CMD_TO_RED;
      end
      {COLOR_HSV_IDLE, COLOR_BLUE}: begin
        nsteps = 2'd2; step0 = CMD_TO_RED; step1 = CMD_TOGGLE;
      end
      default: begin
        nsteps = 2'd0; step0 = CMD_NOP; step1 = CMD_NOP;
      end
    endcase
  end

endmodule

// File: rtl/color_cmd_tx.sv
// Command transmitter for the color FSM: accepts a target state, issues the
// planned command sequence and tracks a shadow of the downstream state.
// Optional feature macro COLOR_CMD_TX_CHECK_EN adds the WAIT state that
// confirms each step on fsm_out, with a mismatch timeout into a sticky error.
module color_cmd_tx
  import color_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_target,
  output logic       req_ready,
  output logic [1:0] cmd,
  input  logic [1:0] fsm_out,
  output logic       done,
  output logic       err,
  output logic [1:0] cur_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
`ifdef COLOR_CMD_TX_CHECK_EN
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
`endif

  logic [2:0] state_q, state_d;
  logic [1:0] shadow_q, shadow_d;
  logic [1:0] nsteps_q, nsteps_d;
  logic [1:0] step0_q, step0_d;
  logic [1:0] step1_q, step1_d;
  logic       idx_q, idx_d;
  logic [1:0] cmd_q, cmd_d;
  logic       done_q, ready_q;
  logic [1:0] plan_nsteps_s, plan_step0_s, plan_step1_s;
  logic [1:0] step_cmd_s;
  logic       more_s;
  logic       illegal_s;

`ifdef COLOR_CMD_TX_CHECK_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q;
  assign illegal_s = (req_target == 2'd3);
  assign err       = err_q;
`else
  logic unused_s;
  assign illegal_s = 1'b0;
  assign err       = 1'b0;
  assign unused_s  = ^{fsm_out, 8'(TIMEOUT)};
`endif

  color_tx_path u_path (
    .shadow (shadow_q),
    .target (req_target),
    .nsteps (plan_nsteps_s),
    .step0  (plan_step0_s),
    .step1  (plan_step1_s)
  );

  assign step_cmd_s = idx_q ? step1_q : step0_q;
  assign more_s     = (~idx_q) & (nsteps_q == 2'd2);
  assign req_ready  = ready_q;
  assign cmd        = cmd_q;
  assign done       = done_q;
  assign cur_state  = shadow_q;

  // Next-state logic: sequencing of accept, issue, confirm, done and error.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    nsteps_d = nsteps_q;
    step0_d  = step0_q;
    step1_d  = step1_q;
    idx_d    = idx_q;
    cmd_d    = CMD_NOP;
`ifdef COLOR_CMD_TX_CHECK_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (illegal_s) begin
            state_d = S_ERR;
          end else begin
            nsteps_d = plan_nsteps_s;
            step0_d  = plan_step0_s;
            step1_d  = plan_step1_s;
            idx_d    = 1'b0;
            if (plan_nsteps_s == 2'd0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ISSUE;
              cmd_d   = plan_step0_s;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        shadow_d = color_next(shadow_q, step_cmd_s);
`ifdef COLOR_CMD_TX_CHECK_EN
        state_d = S_WAIT;
        cnt_d   = 8'd0;
`else
        if (more_s) begin
          idx_d   = 1'b1;
          state_d = S_ISSUE;
          cmd_d   = step1_q;
        end else begin
          state_d = S_DONE;
        end
`endif
      end
`ifdef COLOR_CMD_TX_CHECK_EN
      S_WAIT: begin
        if (fsm_out == color_out(shadow_q)) begin
          if (more_s) begin
            idx_d   = 1'b1;
            state_d = S_ISSUE;
            cmd_d   = step1_q;
          end else begin
            state_d = S_DONE;
          end
        end else if (cnt_q == (TIMEOUT_C - 8'd1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // State, path and registered-output flops; downstream resets to Red too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shadow_q <= COLOR_RED;
      nsteps_q <= 2'd0;
      step0_q  <= CMD_NOP;
      step1_q  <= CMD_NOP;
      idx_q    <= 1'b0;
      cmd_q    <= CMD_NOP;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      nsteps_q <= nsteps_d;
      step0_q  <= step0_d;
      step1_q  <= step1_d;
      idx_q    <= idx_d;
      cmd_q    <= cmd_d;
      done_q   <= (state_d == S_DONE);
      ready_q  <= (state_d == S_IDLE);
    end
  end

`ifdef COLOR_CMD_TX_CHECK_EN
  // Confirm-timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= (state_d == S_ERR);
    end
  end
`endif

endmodule

// File: tb/tb_color_cmd_tx.sv
// Randomized self-checking bench for color_cmd_tx with a behavioural model
// of the downstream color FSM and a path/latency reference model.
module tb_color_cmd_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_target = 2'd0;
  logic       req_ready;
  logic [1:0] cmd;
  logic [1:0] fsm_out;
  logic       done;
  logic       err;
  logic [1:0] cur_state;

  logic [1:0] ds_q;
  logic       force_one = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         model_shadow = 1;

  color_cmd_tx #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .cmd        (cmd),
    .fsm_out    (fsm_out),
    .done       (done),
    .err        (err),
    .cur_state  (cur_state)
  );

  always #5 clk = ~clk;

  // Downstream color FSM model: Blue=0, Red=1, HSV_idle=2, reset to Red.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ds_q <= 2'd1;
    else begin
      case (cmd)
        2'd1: ds_q <= (ds_q == 2'd0) ? 2'd1 : ((ds_q == 2'd1) ? 2'd0 : ds_q);
        2'd2: ds_q <= (ds_q == 2'd1) ? 2'd2 : ds_q;
        2'd0: ds_q <= (ds_q == 2'd2) ? 2'd1 : ds_q;
        default: ds_q <= ds_q;
      endcase
    end
  end

  assign fsm_out = force_one ? 2'd1 : ((ds_q == 2'd0) ? 2'd1 : 2'd2);

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Command that moves the downstream FSM between two adjacent states on the
  // line Blue - Red - HSV_idle.
  function automatic int move_cmd(input int from, input int to);
    if ((from == 0 && to == 1) || (from == 1 && to == 0)) return 1;
    if (from == 1 && to == 2) return 2;
    return 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    force_one = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd", cmd, 8'd3);
    chk("rst_done", done, 8'd0);
    chk("rst_err", err, 8'd0);
    chk("rst_cur", cur_state, 8'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 8'd1);
    model_shadow = 1;
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", req_ready, 8'd1);
  endtask

  // One request checked cycle by cycle against the reference path/latency.
  task automatic run_req(input int target, input bit noisy);
    int exp_cmd[$];
    int pos, nxt, done_idx, ec;
    wait_ready();
    pos = model_shadow;
    if (target <= 2) begin
      while (pos != target) begin
        nxt = (target > pos) ? pos + 1 : pos - 1;
        exp_cmd.push_back(move_cmd(pos, nxt));
`ifdef COLOR_CMD_TX_CHECK_EN
        exp_cmd.push_back(3);
`endif
        pos = nxt;
      end
    end
    done_idx = exp_cmd.size();
    req_valid  = 1'b1;
    req_target = 2'(target);
    @(posedge clk);
    for (int idx = 0; idx <= done_idx; idx++) begin
      @(negedge clk);
      if (noisy && idx < done_idx) begin
        req_valid  = 1'($urandom);
        req_target = 2'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      ec = (idx < done_idx) ? exp_cmd[idx] : 3;
      chk($sformatf("cmd[%0d] t%0d", idx, target), cmd, 8'(ec));
      chk($sformatf("done[%0d] t%0d", idx, target), done, (idx == done_idx) ? 8'd1 : 8'd0);
      chk($sformatf("busy_ready[%0d]", idx), req_ready, 8'd0);
      chk($sformatf("err[%0d]", idx), err, 8'd0);
    end
    @(negedge clk);
    chk("end_ready", req_ready, 8'd1);
    chk("end_done", done, 8'd0);
    chk("end_cur", cur_state, 8'(pos));
    chk("end_fsm", ds_q, 8'(pos));
    model_shadow = pos;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // Directed: Red->Blue, Blue->HSV, HSV->Red, Red->Red, HSV->Blue path.
    run_req(0, 1'b0);
    run_req(2, 1'b0);
    chk("hsv_fsm_out", fsm_out, 8'd2);
    run_req(1, 1'b0);
    run_req(1, 1'b0);
    run_req(2, 1'b1);
    run_req(0, 1'b1);

    // Reset during a two-step path abandons it without a done pulse.
    wait_ready();
    req_valid = 1'b1;
    req_target = 2'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_done0", done, 8'd0);
    @(negedge clk);
    chk("mid_done1", done, 8'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_done", done, 8'd0);
    chk("mid_rst_cmd", cmd, 8'd3);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mid_after_done%0d", k), done, 8'd0);
    end
    chk("mid_cur", cur_state, 8'd1);
    chk("mid_ready", req_ready, 8'd1);
    model_shadow = 1;

`ifdef COLOR_CMD_TX_CHECK_EN
    // Confirm timeout: fsm_out stuck at Blue code while going Red->HSV.
    force_one = 1'b1;
    wait_ready();
    req_valid = 1'b1;
    req_target = 2'd2;
    @(posedge clk);
    for (int idx = 0; idx < 14; idx++) begin
      @(negedge clk);
      if (idx == 0) chk("to_cmd0", cmd, 8'd2);
      chk($sformatf("to_err[%0d]", idx), err, (idx >= 9) ? 8'd1 : 8'd0);
      chk($sformatf("to_ready[%0d]", idx), req_ready, 8'd0);
      if (idx >= 9) chk($sformatf("to_cmd[%0d]", idx), cmd, 8'd3);
    end
    req_valid = 1'b0;
    do_reset();

    // Illegal target goes to the sticky error state.
    wait_ready();
    req_valid = 1'b1;
    req_target = 2'd3;
    @(posedge clk);
    for (int idx = 0; idx < 5; idx++) begin
      @(negedge clk);
      chk($sformatf("ill_err[%0d]", idx), err, 8'd1);
      chk($sformatf("ill_ready[%0d]", idx), req_ready, 8'd0);
      chk($sformatf("ill_done[%0d]", idx), done, 8'd0);
      chk($sformatf("ill_cmd[%0d]", idx), cmd, 8'd3);
    end
    chk("ill_cur", cur_state, 8'd1);
    req_valid = 1'b0;
    do_reset();
`else
    // Illegal target is dropped with a done pulse, shadow unchanged.
    run_req(0, 1'b0);
    run_req(3, 1'b0);
    run_req(2, 1'b0);
    run_req(3, 1'b1);
`endif

    // Randomized requests.
    for (int r = 0; r < 40; r++) begin
`ifdef COLOR_CMD_TX_CHECK_EN
      run_req(int'($urandom_range(0, 2)), 1'($urandom));
`else
      run_req(int'($urandom_range(0, 3)), 1'($urandom));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_cmd_tx.md
COLOR_CMD_TX -- requirements
Module: color_cmd_tx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8, giving the number of mismatched confirm cycles before error (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1 bit: target request valid.
REQ-005 SHALL have port req_target, input, 2 bits: target state, 0 Blue, 1 Red, 2 HSV_idle; 3 is illegal.
REQ-006 SHALL have port req_ready, output, 1 bit: request accepted when high together with req_valid.
REQ-007 SHALL have port cmd, output, 2 bits: command driven into the color FSM's 2-bit "in" port.
REQ-008 SHALL have port fsm_out, input, 2 bits: the color FSM's "out" port; Blue shows 1, Red and HSV_idle show 2.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a request completes.
REQ-010 SHALL have port err, output, 1 bit: sticky error flag.
REQ-011 SHALL have port cur_state, output, 2 bits: shadow copy of the downstream FSM state.

Function
REQ-012 SHALL use these command codes: 1 toggles Blue/Red, 2 moves Red to HSV_idle, 0 moves HSV_idle to Red, 3 is NOP (no effect in any state).
REQ-013 SHALL drive cmd=3 in every state except ISSUE.
REQ-014 SHALL plan paths as follows: Blue->Red 1; Red->Blue 1; Red->HSV 2; HSV->Red 0; Blue->HSV 1,2; HSV->Blue 0,1; target equal to shadow gives zero steps.
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, DONE, ERR.
REQ-016 SHALL assert req_ready only in IDLE.
REQ-017 SHALL latch the path on accept; a zero-step path goes to DONE, otherwise the block goes to ISSUE.
REQ-018 SHALL drive the current step code on cmd for exactly one cycle in ISSUE, update the shadow at the end of that cycle, then go to WAIT.
REQ-019 SHALL, in WAIT, compare fsm_out with the expected code of the shadow; on a match go to ISSUE if a step remains, else DONE.
REQ-020 SHALL clear the WAIT mismatch counter on WAIT entry; TIMEOUT consecutive mismatched cycles SHALL go to ERR.
REQ-021 SHALL assert done=1 only in DONE, for one cycle, then return to IDLE.
REQ-022 SHALL, in ERR, hold err=1, req_ready=0 and cmd=3 until reset.
REQ-023 SHALL, on accept with req_target=3, go to ERR the next cycle and leave the shadow unchanged.
REQ-024 SHALL give these latencies from accept edge N (check enabled): done at N+1 for 0 steps, N+3 for 1 step, N+5 for 2 steps.
REQ-025 SHALL ignore req_valid outside IDLE; there is no queuing.

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, shadow=Red (the downstream reset state), cmd=3, done=0, err=0, counter=0, with req_ready=1 once out of reset.
REQ-027 SHALL, if reset is asserted mid-path, abandon the path immediately with no done pulse; the downstream FSM is reset by the same rst_n.

Configuration
REQ-028 SHALL, with COLOR_CMD_TX_CHECK_EN defined, include WAIT, the counter, fsm_out comparison and err.
REQ-029 SHALL, without COLOR_CMD_TX_CHECK_EN, omit WAIT so ISSUE chains directly to the next ISSUE or DONE, ignore fsm_out, and tie err=0; illegal targets are then dropped with a done pulse. Latencies become N+2 for 1 step and N+3 for 2 steps.

Structure
REQ-030 SHALL take from shared package color_pkg: the state enum (Blue=0, Red=1, HSV_idle=2), command constants CMD_TOGGLE=1, CMD_TO_HSV=2, CMD_TO_RED=0, CMD_NOP=3, and output codes OUT_BLUE=1, OUT_RED=2.
REQ-031 SHALL place the path planner in combinational sub-module color_tx_path, with inputs (shadow, target) and outputs (nsteps, step0, step1).

Verification
REQ-032 SHALL cover: with the bench driving the color FSM model, after reset request target 0 -> cmd=1 for one cycle, done at N+3, cur_state=0.
REQ-033 SHALL cover: from Blue, request 2 -> cmd sequence 1,3,2,3, done at N+5, fsm_out=2, cur_state=2.
REQ-034 SHALL cover: from Red, request 1 -> no non-NOP cmd, done at N+1.
REQ-035 SHALL cover: with TIMEOUT=8 and fsm_out forced to 1, request 2 from Red -> err=1 after 8 WAIT cycles, req_ready stays 0 until rst_n.
REQ-036 SHALL cover: rst_n pulsed low during the WAIT of a 2-step path -> no done, cur_state=1, req_ready=1 after release.
REQ-037 SHALL cover: request target 3 -> err=1 with the macro defined; without the macro, done pulses and cur_state is unchanged.
